// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file with clear sweep.
package regfile_pkg;

    // Controller state: idle (normal writes) or clearing entries one per cycle
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Address width for a given depth; never narrower than one bit
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_mp_array.sv
// Storage array with per-entry valid bits, one write port and two
// combinational read ports. Write source (normal or sweep) is chosen by the parent.
module regfile_mp_array
    import regfile_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wvalid,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    // Entry and valid-bit update; reset wipes the whole array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else if (wen) begin
            mem[waddr]   <= wdata;
            valid[waddr] <= wvalid;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rvalid_a = valid[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign rvalid_b = valid[raddr_b];

endmodule

// File: rtl/regfile_mp_sweep.sv
// Parametrised two-read-port register file with valid bits, optional
// write-to-read bypass and a sequential clear-sweep engine.
module regfile_mp_sweep
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop
);

    state_t           state_p0, state_nxt;
    logic [AW-1:0]    idx_p0, idx_nxt;

    logic             arr_wen;
    logic [AW-1:0]    arr_waddr;
    logic [WIDTH-1:0] arr_wdata;
    logic             arr_wvalid;

    logic [WIDTH-1:0] mem_a, mem_b;
    logic             mvld_a, mvld_b;
    logic             hit_a, hit_b;

    logic [WIDTH-1:0] rdata_a_p1, rdata_b_p1;
    logic             vld_a_p1, vld_b_p1;
    logic             wr_drop_p1;

    // FSM state and sweep index register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            idx_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            idx_p0   <= idx_nxt;
        end
    end

    // Next-state logic and array write-port selection (sweep overrides user writes)
    always_comb begin
        state_nxt  = state_p0;
        idx_nxt    = idx_p0;
        arr_wen    = 1'b0;
        arr_waddr  = waddr;
        arr_wdata  = wdata;
        arr_wvalid = 1'b1;
        case (state_p0)
            IDLE: begin
                arr_wen = we;
                if (clr_req) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                arr_wen    = 1'b1;
                arr_waddr  = idx_p0;
                arr_wdata  = '0;
                arr_wvalid = 1'b0;
                idx_nxt    = idx_p0 + AW'(1);
                if (idx_p0 == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    regfile_mp_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .wen      (arr_wen),
        .waddr    (arr_waddr),
        .wdata    (arr_wdata),
        .wvalid   (arr_wvalid),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (mem_a),
        .rvalid_a (mvld_a),
        .rdata_b  (mem_b),
        .rvalid_b (mvld_b)
    );

    // Bypass covers both user writes and sweep clears hitting the read address
    assign hit_a = BYPASS && arr_wen && (raddr_a == arr_waddr);
    assign hit_b = BYPASS && arr_wen && (raddr_b == arr_waddr);

    // ---- stage p1: registered read data, valid bits and drop pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_p1 <= '0;
            rdata_b_p1 <= '0;
            vld_a_p1   <= 1'b0;
            vld_b_p1   <= 1'b0;
            wr_drop_p1 <= 1'b0;
        end else begin
            rdata_a_p1 <= hit_a ? arr_wdata  : mem_a;
            vld_a_p1   <= hit_a ? arr_wvalid : mvld_a;
            rdata_b_p1 <= hit_b ? arr_wdata  : mem_b;
            vld_b_p1   <= hit_b ? arr_wvalid : mvld_b;
            wr_drop_p1 <= we && (state_p0 == SWEEP);
        end
    end

    assign rdata_a  = rdata_a_p1;
    assign rdata_b  = rdata_b_p1;
    assign rvalid_a = vld_a_p1;
    assign rvalid_b = vld_b_p1;
    assign wr_drop  = wr_drop_p1;
    assign busy     = (state_p0 == SWEEP);

endmodule

// File: tb/tb_regfile_mp_sweep.sv
// Bench for regfile_mp_sweep: one BYPASS=0 and one BYPASS=1 instance share
// stimulus; a behavioural model predicts both every cycle.
module tb_regfile_mp_sweep;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, we, clr_req;
    logic [1:0] waddr, raddr_a, raddr_b;
    logic [3:0] wdata;

    // index 0: BYPASS=0, index 1: BYPASS=1
    logic [3:0] rd_a [2];
    logic [3:0] rd_b [2];
    logic       rv_a [2];
    logic       rv_b [2];
    logic       bsy  [2];
    logic       drp  [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_sweep #(.WIDTH(4), .DEPTH(DEPTH), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a[0]), .rdata_b(rd_b[0]), .rvalid_a(rv_a[0]), .rvalid_b(rv_b[0]),
        .clr_req(clr_req), .busy(bsy[0]), .wr_drop(drp[0]));

    regfile_mp_sweep #(.WIDTH(4), .DEPTH(DEPTH), .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rd_a[1]), .rdata_b(rd_b[1]), .rvalid_a(rv_a[1]), .rvalid_b(rv_b[1]),
        .clr_req(clr_req), .busy(bsy[1]), .wr_drop(drp[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sweep modelled as "clears remaining": entry cleared this edge is DEPTH-left.
    logic [3:0] m_mem [2][DEPTH];
    bit         m_val [2][DEPTH];
    int         m_left;
    logic [3:0] e_rd_a [2];
    logic [3:0] e_rd_b [2];
    bit         e_rv_a [2];
    bit         e_rv_b [2];
    bit         e_busy, e_drop;
    bit         w_do, w_v;
    int         w_a;
    logic [3:0] w_d;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[b][i] = 4'h0;
                    m_val[b][i] = 1'b0;
                end
                e_rd_a[b] = 4'h0; e_rd_b[b] = 4'h0;
                e_rv_a[b] = 1'b0; e_rv_b[b] = 1'b0;
            end
            m_left = 0;
            e_busy = 1'b0;
            e_drop = 1'b0;
        end else begin
            w_do = 1'b0; w_a = 0; w_d = 4'h0; w_v = 1'b0;
            if (m_left > 0) begin
                w_do = 1'b1; w_a = DEPTH - m_left;
            end else if (we) begin
                w_do = 1'b1; w_a = int'(waddr); w_d = wdata; w_v = 1'b1;
            end
            for (int b = 0; b < 2; b++) begin
                if (b == 1 && w_do && int'(raddr_a) == w_a) begin
                    e_rd_a[b] = w_d; e_rv_a[b] = w_v;
                end else begin
                    e_rd_a[b] = m_mem[b][raddr_a]; e_rv_a[b] = m_val[b][raddr_a];
                end
                if (b == 1 && w_do && int'(raddr_b) == w_a) begin
                    e_rd_b[b] = w_d; e_rv_b[b] = w_v;
                end else begin
                    e_rd_b[b] = m_mem[b][raddr_b]; e_rv_b[b] = m_val[b][raddr_b];
                end
                if (w_do) begin
                    m_mem[b][w_a] = w_d;
                    m_val[b][w_a] = w_v;
                end
            end
            e_drop = we && (m_left > 0);
            if (m_left > 0) m_left = m_left - 1;
            else if (clr_req) m_left = DEPTH;
            e_busy = (m_left > 0);
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started) begin
            for (int b = 0; b < 2; b++) begin
                chk($sformatf("cycle_dut%0d{rda,rva,rdb,rvb,busy,drop}", b),
                    {20'd0, rd_a[b], rv_a[b], rd_b[b], rv_b[b], bsy[b], drp[b]},
                    {20'd0, e_rd_a[b], e_rv_a[b], e_rd_b[b], e_rv_b[b], e_busy, e_drop});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input bit w, input logic [1:0] wa, input logic [3:0] wd,
                        input logic [1:0] ra, input logic [1:0] rb, input bit c);
        rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; clr_req = c;
        @(negedge clk);
    endtask

    int busy_cnt;

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, 0);

        // 1: reset contents on every address, both ports
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 2'(i), 2'(3 - i), 0);
            chk("t1_rdata_a", rd_a[1], 0);
            chk("t1_rvalid_b", rv_b[1], 0);
            chk("t1_busy", bsy[1], 0);
        end

        // 2: basic writes and reads
        step(0, 1, 0, 4'hA, 0, 0, 0);
        step(0, 1, 1, 4'h5, 0, 0, 0);
        step(0, 1, 3, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 3, 0, 0);
        chk("t2_rdata_a", rd_a[0], 4'hF);
        chk("t2_rdata_b", rd_b[0], 4'hA);
        chk("t2_rvalid_ab", {rv_a[0], rv_b[0]}, 2'b11);
        step(0, 0, 0, 0, 2, 1, 0);
        chk("t2_empty_rdata", rd_a[1], 0);
        chk("t2_empty_rvalid", rv_a[1], 0);
        chk("t2_rdata_b1", rd_b[1], 4'h5);

        // 3: same-edge write/read collision
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 4'h7, 2, 0, 0);
        chk("t3_byp1_rdata", rd_a[1], 4'h7);
        chk("t3_byp1_rvalid", rv_a[1], 1);
        chk("t3_byp0_rdata", rd_a[0], 4'h0);
        chk("t3_byp0_rvalid", rv_a[0], 0);
        step(0, 0, 0, 0, 2, 0, 0);
        chk("t3_byp0_later", {rv_a[0], rd_a[0]}, 5'h17);

        // 4: fill, sweep, dropped writes, ignored second clr_req
        for (int i = 0; i < DEPTH; i++) step(0, 1, 2'(i), 4'hC, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t4_busy_start", bsy[1], 1);
        busy_cnt = 1;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 1, 4'h3, 1, 2, (k == 1));
            chk("t4_wr_drop", drp[1], 1);
            if (bsy[1]) busy_cnt++;
            else break;
        end
        chk("t4_busy_cycles", busy_cnt, DEPTH);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t4_drop_clear", drp[0], 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 2'(i), 2'(i), 0);
            chk("t4_cleared", {rv_a[0], rd_a[0], rv_b[1], rd_b[1]}, 0);
        end

        // 5: clr_req together with a write
        step(0, 1, 0, 4'h9, 0, 0, 1);
        chk("t5_write_bypassed", rd_a[1], 4'h9);
        chk("t5_busy", bsy[0], 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t5_final", {rv_a[0], rd_a[0], rv_a[1], rd_a[1]}, 0);

        // 6: reset mid-sweep, then immediate write
        step(0, 1, 3, 4'h4, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 3, 3, 0);
        step(1, 0, 0, 0, 3, 3, 0);
        chk("t6_after_rst", {bsy[1], drp[1], rv_a[1], rd_a[1], rv_b[1], rd_b[1]}, 0);
        step(0, 1, 3, 4'h4, 0, 0, 0);
        step(0, 0, 0, 0, 3, 3, 0);
        chk("t6_readback0", {rv_a[0], rd_a[0]}, 5'h14);
        chk("t6_readback1", {rv_b[1], rd_b[1]}, 5'h14);

        // Random traffic, checked cycle by cycle against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
                 2'($urandom), 2'($urandom), ($urandom_range(0, 11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
